// File: rtl/mcu0_pkg.sv
// Shared definitions for the mcu0 multi-cycle accumulator core:
// opcode encodings, FSM state type and status-flag bit positions.
package mcu0_pkg;

   localparam logic [3:0] OP_LD   = 4'h0;
   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_JMP  = 4'h2;
   localparam logic [3:0] OP_ST   = 4'h3;
   localparam logic [3:0] OP_CMP  = 4'h4;
   localparam logic [3:0] OP_JEQ  = 4'h5;
   localparam logic [3:0] OP_SUB  = 4'h6;
   localparam logic [3:0] OP_AND  = 4'h7;
   localparam logic [3:0] OP_OR   = 4'h8;
   localparam logic [3:0] OP_XOR  = 4'h9;
   localparam logic [3:0] OP_JLT  = 4'hA;
   localparam logic [3:0] OP_LDI  = 4'hB;
   localparam logic [3:0] OP_HALT = 4'hF;

   localparam int unsigned FLAG_N = 1;
   localparam int unsigned FLAG_Z = 0;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_MEMRD,
      S_MEMWR,
      S_HALT
   } mcu0_state_t;

endpackage

// File: rtl/mcu0_alu.sv
// Combinational ALU for mcu0: result for the accumulator opcodes plus
// signed-less-than and equality for CMP.
module mcu0_alu
   import mcu0_pkg::*;
#(
   parameter int W = 16
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [3:0]   op,
   output logic [W-1:0] y,
   output logic         lt,
   output logic         eq
);

   always_comb begin
      y = a;
      case (op)
         OP_LD:   y = b;
         OP_ADD:  y = a + b;
         OP_SUB:  y = a - b;
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_XOR:  y = a ^ b;
         default: y = a;
      endcase
   end

   assign lt = $signed(a) < $signed(b);
   assign eq = (a == b);

endmodule

// File: rtl/mcu0_core.sv
// mcu0 multi-cycle accumulator core: fetch/decode/memory FSM with a
// registered request/ready port to word-addressed memory.
module mcu0_core
   import mcu0_pkg::*;
#(
   parameter int          W        = 16,
   parameter int          AW       = 12,
   parameter int unsigned RESET_PC = 0
) (
   input  logic          clock,
   input  logic          reset_n,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [W-1:0]  mem_wdata,
   input  logic [W-1:0]  mem_rdata,
   input  logic          mem_ready,
   output logic          halted,
   output logic [W-1:0]  acc_out,
   output logic [AW-1:0] pc_out,
   output logic [1:0]    sw_out
);

   mcu0_state_t   state;
   logic [AW-1:0] pc;
   logic [W-1:0]  acc;
   logic [W-1:0]  ir;
   logic [1:0]    sw;

   logic [3:0]    op;
   logic [AW-1:0] ea;
   logic [W-1:0]  ldi_val;
   logic [AW-1:0] next_pc;
   logic [W-1:0]  alu_y;
   logic          alu_lt;
   logic          alu_eq;

   assign op      = ir[W-1:W-4];
   assign ea      = ir[AW-1:0];
   assign ldi_val = {4'b0000, ir[W-5:0]};

   mcu0_alu #(.W(W)) u_alu (
      .a  (acc),
      .b  (mem_rdata),
      .op (op),
      .y  (alu_y),
      .lt (alu_lt),
      .eq (alu_eq)
   );

   always_comb begin
      next_pc = pc;
      case (op)
         OP_JMP:  next_pc = ea;
         OP_JEQ:  if (sw[FLAG_Z]) next_pc = ea;
         OP_JLT:  if (sw[FLAG_N]) next_pc = ea;
         default: next_pc = pc;
      endcase
   end

   // Requests are issued one edge ahead of the state that owns them, so
   // FETCH/MEMRD/MEMWR each see mem_req already high on entry; only the
   // very first fetch after reset spends one idle cycle issuing it.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_FETCH;
         pc        <= AW'(RESET_PC);
         acc       <= '0;
         ir        <= '0;
         sw        <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         halted    <= 1'b0;
      end else begin
         case (state)
            S_FETCH: begin
               if (!mem_req) begin
                  mem_req  <= 1'b1;
                  mem_we   <= 1'b0;
                  mem_addr <= pc;
               end else if (mem_ready) begin
                  ir      <= mem_rdata;
                  pc      <= pc + AW'(1);
                  mem_req <= 1'b0;
                  state   <= S_DECODE;
               end
            end
            S_DECODE: begin
               case (op)
                  OP_LD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_CMP: begin
                     mem_req  <= 1'b1;
                     mem_we   <= 1'b0;
                     mem_addr <= ea;
                     state    <= S_MEMRD;
                  end
                  OP_ST: begin
                     mem_req   <= 1'b1;
                     mem_we    <= 1'b1;
                     mem_addr  <= ea;
                     mem_wdata <= acc;
                     state     <= S_MEMWR;
                  end
                  OP_HALT: begin
                     halted <= 1'b1;
                     state  <= S_HALT;
                  end
                  default: begin
                     if (op == OP_LDI) acc <= ldi_val;
                     pc       <= next_pc;
                     mem_req  <= 1'b1;
                     mem_we   <= 1'b0;
                     mem_addr <= next_pc;
                     state    <= S_FETCH;
                  end
               endcase
            end
            S_MEMRD: begin
               if (mem_ready) begin
                  if (op == OP_CMP) begin
                     sw[FLAG_N] <= alu_lt;
                     sw[FLAG_Z] <= alu_eq;
                  end else begin
                     acc <= alu_y;
                  end
                  mem_we   <= 1'b0;
                  mem_addr <= pc;
                  state    <= S_FETCH;
               end
            end
            S_MEMWR: begin
               if (mem_ready) begin
                  mem_we   <= 1'b0;
                  mem_addr <= pc;
                  state    <= S_FETCH;
               end
            end
            S_HALT: begin
               mem_req <= 1'b0;
               halted  <= 1'b1;
            end
            default: state <= S_FETCH;
         endcase
      end
   end

   assign acc_out = acc;
   assign pc_out  = pc;
   assign sw_out  = sw;

endmodule
